// File: rtl/inert_intf.sv
// Inertial-sensor front end: configures the IMU through the SPI monarch, reads pitch rate
// and Z-acceleration on every data-ready interrupt, and fuses them into a pitch estimate.
module inert_intf #(
  parameter int          TMR_W          = 16,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic        [15:0] rd_data,
  output logic               wrt,
  output logic        [15:0] cmd,
  output logic               vld,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt
);

  typedef enum logic [2:0] {INIT_WAIT, CFG, IDLE, RD, FUSE} state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [1:0]         idx;
  logic               busy;
  logic               int_ff1, int_ff2, int_ff3, int_rise;
  logic [7:0]         rate_l, rate_h, az_l, az_h;
  logic signed [26:0] ptch_int;

  logic [15:0]        rt_next, az_corr;
  logic signed [25:0] az_ext, prod;
  logic signed [15:0] ptch_acc;
  logic [26:0]        fuse_val;
  logic signed [26:0] int_next;
  logic               unused_bits;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1053;
      2'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'hA200;
      2'd1:    return 16'hA300;
      2'd2:    return 16'hAC00;
      default: return 16'hAD00;
    endcase
  endfunction

  // INT is asynchronous: two flops to settle it, a third to find its rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
      int_ff3 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      int_ff3 <= int_ff2;
    end
  end

  assign int_rise = int_ff2 & ~int_ff3;

  // Fusion datapath, consumed only in the FUSE cycle.
  assign rt_next  = {rate_h, rate_l} - PTCH_RT_OFFSET;
  assign az_corr  = {az_h, az_l} - AZ_OFFSET;
  assign az_ext   = {{10{az_corr[15]}}, az_corr};
  assign prod     = az_ext * 26'sd327;
  assign ptch_acc = {{3{prod[25]}}, prod[25:13]};
  assign fuse_val = (ptch_acc > ptch) ? 27'd1024 : 27'h7FFFC00;
  assign int_next = ptch_int - {{11{rt_next[15]}}, rt_next} + fuse_val;
  assign ptch     = ptch_int[26:11];

  assign unused_bits = ^{rd_data[15:8], prod[12:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      tmr      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      wrt      <= 1'b0;
      cmd      <= '0;
      vld      <= 1'b0;
      ptch_rt  <= '0;
      ptch_int <= '0;
      rate_l   <= '0;
      rate_h   <= '0;
      az_l     <= '0;
      az_h     <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      unique case (state)
        INIT_WAIT: begin
          tmr <= tmr + TMR_W'(1);
          if (&tmr) begin
            state <= CFG;
            idx   <= 2'd0;
            busy  <= 1'b1;
            wrt   <= 1'b1;
            cmd   <= cfg_cmd(2'd0);
          end
        end
        CFG: begin
          if (busy && done) begin
            if (idx == 2'd3) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx <= idx + 2'd1;
              wrt <= 1'b1;
              cmd <= cfg_cmd(idx + 2'd1);
            end
          end
        end
        IDLE: begin
          // A done with nothing outstanding lands here and is simply dropped.
          if (int_rise) begin
            state <= RD;
            idx   <= 2'd0;
            busy  <= 1'b1;
            wrt   <= 1'b1;
            cmd   <= rd_cmd(2'd0);
          end
        end
        RD: begin
          if (busy && done) begin
            case (idx)
              2'd0:    rate_l <= rd_data[7:0];
              2'd1:    rate_h <= rd_data[7:0];
              2'd2:    az_l   <= rd_data[7:0];
              default: az_h   <= rd_data[7:0];
            endcase
            if (idx == 2'd3) begin
              busy  <= 1'b0;
              state <= FUSE;
            end else begin
              idx <= idx + 2'd1;
              wrt <= 1'b1;
              cmd <= rd_cmd(idx + 2'd1);
            end
          end
        end
        FUSE: begin
          ptch_rt  <= rt_next;
          ptch_int <= int_next;
          vld      <= 1'b1;
          state    <= IDLE;
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_intf.sv
// Self-checking bench for inert_intf: SPI responder, output monitor, vector table,
// multi-cycle corner sequences and randomized bursts against an arithmetic pitch model.
`timescale 1ns/1ps
module tb_inert_intf;

  localparam int          TMR_W  = 4;
  localparam logic [15:0] RT_OFF = 16'h0050;
  localparam logic [15:0] AZ_OFF = 16'h00A0;
  localparam logic [15:0] CFG_CMDS [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [15:0] RD_CMDS  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;

  inert_intf #(
    .TMR_W(TMR_W), .PTCH_RT_OFFSET(RT_OFF), .AZ_OFFSET(AZ_OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  logic [15:0] wrt_q[$];
  int          wrt_cyc_q[$];
  logic [15:0] vld_ptch = '0;
  logic [15:0] vld_rt = '0;
  int          resp_lat = 3;
  logic [15:0] raw_rate = '0;
  logic [15:0] raw_az = '0;
  bit          stray_req = 1'b0;
  longint      m_int = 0;

  typedef struct {
    logic [15:0] rate;
    logic [15:0] az;
    logic [15:0] e_rt;
    logic [15:0] e_ptch;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pitch model: one fusion step from the arithmetic rules, 27-bit wrapping integrator.
  task automatic model_step(input logic [15:0] rate, input logic [15:0] az_raw,
                            output logic [15:0] e_rt, output logic [15:0] e_ptch);
    logic [15:0] d_rt, d_az;
    int rt, az, acc, cur, fuse;
    longint nxt;
    d_rt = rate - RT_OFF;
    d_az = az_raw - AZ_OFF;
    rt   = int'($signed(d_rt));
    az   = int'($signed(d_az));
    acc  = (az * 327) >>> 13;
    cur  = int'(m_int >>> 11);
    fuse = (acc > cur) ? 1024 : -1024;
    nxt  = m_int - longint'(rt) + longint'(fuse);
    nxt  = ((nxt % 64'sd134217728) + 64'sd134217728) % 64'sd134217728;
    if (nxt >= 64'sd67108864) nxt = nxt - 64'sd134217728;
    m_int  = nxt;
    e_rt   = d_rt;
    e_ptch = 16'(m_int >>> 11);
  endtask

  function automatic logic [7:0] resp_byte(input logic [15:0] c);
    case (c)
      16'hA200: return raw_rate[7:0];
      16'hA300: return raw_rate[15:8];
      16'hAC00: return raw_az[7:0];
      16'hAD00: return raw_az[15:8];
      default:  return 8'($urandom);
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples 1 ns after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (wrt) begin
      wrt_q.push_back(cmd);
      wrt_cyc_q.push_back(cyc);
      wrt_cnt++;
    end
    if (vld) begin
      vld_cnt++;
      vld_ptch = ptch;
      vld_rt   = ptch_rt;
    end
  end

  // SPI responder: done arrives resp_lat cycles after wrt; junk in the high byte.
  initial begin
    logic [15:0] pend_cmd;
    int pend_cnt;
    pend_cmd = '0;
    pend_cnt = 0;
    done     = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      done    = 1'b0;
      rd_data = 16'($urandom);
      if (!rst_n) begin
        pend_cnt = 0;
      end else if (wrt) begin
        pend_cmd = cmd;
        pend_cnt = resp_lat;
      end else if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          check("cmd_hold", 32'(cmd), 32'(pend_cmd));
          done    = 1'b1;
          rd_data = {8'($urandom), resp_byte(pend_cmd)};
        end
      end else if (stray_req) begin
        stray_req = 1'b0;
        done      = 1'b1;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic int_pulse();
    @(negedge clk);
    INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic wait_vld(input int v0);
    int n;
    n = 0;
    while (vld_cnt == v0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("vld_seen", 32'(vld_cnt != v0), 32'h1);
  endtask

  task automatic check_burst(input int w0, input int v0,
                             input logic [15:0] e_rt, input logic [15:0] e_ptch);
    check("burst_wrt_count", wrt_cnt - w0, 4);
    for (int i = 0; i < 4; i++)
      if (wrt_q.size() > w0 + i) check("burst_cmd", 32'(wrt_q[w0+i]), 32'(RD_CMDS[i]));
    check("burst_vld_count", vld_cnt - v0, 1);
    check("burst_ptch_rt", 32'(vld_rt), 32'(e_rt));
    check("burst_ptch", 32'(vld_ptch), 32'(e_ptch));
    check("ptch_hold", 32'(ptch), 32'(vld_ptch));
    check("ptch_rt_hold", 32'(ptch_rt), 32'(vld_rt));
  endtask

  task automatic burst(input logic [15:0] rate, input logic [15:0] az,
                       input logic [15:0] e_rt, input logic [15:0] e_ptch);
    int w0, v0;
    raw_rate = rate;
    raw_az   = az;
    w0 = wrt_cnt;
    v0 = vld_cnt;
    int_pulse();
    wait_vld(v0);
    repeat (2) @(negedge clk);
    check_burst(w0, v0, e_rt, e_ptch);
  endtask

  task automatic check_init(input int w0, input int rel);
    int n;
    n = 0;
    while (wrt_cnt < w0 + 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("init_wrt_count", wrt_cnt - w0, 4);
    for (int i = 0; i < 4; i++)
      if (wrt_q.size() > w0 + i) check("init_cmd", 32'(wrt_q[w0+i]), 32'(CFG_CMDS[i]));
    if (wrt_cyc_q.size() > w0) check("init_first_wrt", wrt_cyc_q[w0] - rel, 16);
    for (int i = 1; i < 4; i++)
      if (wrt_cyc_q.size() > w0 + i)
        check("init_spacing", wrt_cyc_q[w0+i] - wrt_cyc_q[w0+i-1], 4);
  endtask

  initial begin
    int w0, v0, rel, n;
    logic [15:0] e_rt, e_ptch, prev, r_rate, r_az;

    tbl[0] = '{16'h0050, 16'h00A0, 16'h0000, 16'hFFFF};
    tbl[1] = '{16'h0850, 16'h00A0, 16'h0800, 16'hFFFF};
    tbl[2] = '{16'h0850, 16'h00A0, 16'h0800, 16'hFFFE};
    tbl[3] = '{16'h0050, 16'h40A0, 16'h0000, 16'hFFFF};
    tbl[4] = '{16'h0040, 16'h00A0, 16'hFFF0, 16'hFFFF};
    tbl[5] = '{16'h0050, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[6] = '{16'h8050, 16'h00A0, 16'h8000, 16'h000F};

    rst_n = 1'b0;
    INT   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wrt", 32'(wrt), 32'h0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_vld", 32'(vld), 32'h0);
    check("rst_ptch", 32'(ptch), 32'h0);
    check("rst_ptch_rt", 32'(ptch_rt), 32'h0);

    // Power-on wait and configuration writes.
    resp_lat = 3;
    w0 = wrt_cnt;
    rst_n = 1'b1;
    rel = cyc;
    check_init(w0, rel);

    // A done with nothing outstanding must not start anything.
    w0 = wrt_cnt;
    v0 = vld_cnt;
    stray_req = 1'b1;
    repeat (8) @(negedge clk);
    check("stray_done_wrt", wrt_cnt - w0, 0);
    check("stray_done_vld", vld_cnt - v0, 0);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      model_step(tbl[i].rate, tbl[i].az, e_rt, e_ptch);
      burst(tbl[i].rate, tbl[i].az, tbl[i].e_rt, tbl[i].e_ptch);
    end

    // Second INT edge while the read burst is in flight is discarded.
    raw_rate = 16'h0850;
    raw_az   = 16'h00A0;
    model_step(raw_rate, raw_az, e_rt, e_ptch);
    w0 = wrt_cnt;
    v0 = vld_cnt;
    int_pulse();
    n = 0;
    while (wrt_cnt < w0 + 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    int_pulse();
    wait_vld(v0);
    repeat (30) @(negedge clk);
    check_burst(w0, v0, e_rt, e_ptch);

    // Reset in the cycle of the second read request.
    raw_rate = 16'h0850;
    raw_az   = 16'h00A0;
    w0 = wrt_cnt;
    v0 = vld_cnt;
    int_pulse();
    n = 0;
    while (wrt_cnt < w0 + 2 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rst_mid_wrt_high", 32'(wrt), 32'h1);
    rst_n = 1'b0;
    m_int = 0;
    #1;
    check("rst_mid_wrt", 32'(wrt), 32'h0);
    check("rst_mid_cmd", 32'(cmd), 32'h0);
    check("rst_mid_vld", 32'(vld), 32'h0);
    check("rst_mid_ptch", 32'(ptch), 32'h0);
    check("rst_mid_ptch_rt", 32'(ptch_rt), 32'h0);
    w0 = wrt_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    repeat (2) @(negedge clk);
    stray_req = 1'b1;
    check_init(w0, rel);
    check("rst_mid_no_vld", vld_cnt - v0, 0);

    // Accelerometer pull from a zero integrator: rise, then dither around ptch_acc.
    resp_lat = 1;
    prev = 16'h0000;
    for (int i = 0; i < 1340; i++) begin
      model_step(16'h0050, 16'h40A0, e_rt, e_ptch);
      burst(16'h0050, 16'h40A0, e_rt, e_ptch);
      if (i < 1300) check("accel_rising", 32'($signed(vld_ptch) >= $signed(prev)), 32'h1);
      prev = vld_ptch;
    end
    check("accel_settled", 32'($signed(vld_ptch) >= 16'sd653 && $signed(vld_ptch) <= 16'sd654), 32'h1);

    // Constant pitch rate: estimate falls every burst.
    for (int i = 0; i < 100; i++) begin
      model_step(16'h0850, 16'h00A0, e_rt, e_ptch);
      burst(16'h0850, 16'h00A0, e_rt, e_ptch);
      check("rate_const_rt", 32'(vld_rt), 32'h0800);
      check("rate_falling", 32'($signed(vld_ptch) < $signed(prev)), 32'h1);
      prev = vld_ptch;
    end

    // Random samples and SPI latencies.
    for (int i = 0; i < 40; i++) begin
      resp_lat = int'($urandom_range(4, 1));
      r_rate = 16'($urandom);
      r_az   = 16'($urandom);
      model_step(r_rate, r_az, e_rt, e_ptch);
      burst(r_rate, r_az, e_rt, e_ptch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
